// File: rtl/shift_pkg.sv
// Shared types and constants for the serial word receiver.
package shift_pkg;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} deser_state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage : shift_pkg

// File: rtl/word_out_buf.sv
// One-entry valid/ready output register; flags a completed word it had to drop.
module word_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_req_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             drop_o
);

    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             load_s;

    // A slot is free when empty or when the held word leaves this cycle.
    always_comb begin
        load_s = load_req_i && (!valid_q || ready_i);
        drop_o = load_req_i && valid_q && !ready_i;
    end

    // Holding register and its valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else if (load_s) begin
            word_q  <= word_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign word_o  = word_q;
    assign valid_o = valid_q;

endmodule : word_out_buf

// File: rtl/serial_word_deser.sv
// Serial-in/parallel-out receiver: gathers WIDTH bits in either bit order and
// hands each word to a one-deep valid/ready buffer, flagging aborts and overruns.
module serial_word_deser
    import shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             msb_first,
    input  logic             cont,
    input  logic             sdi,
    input  logic             sdi_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_ovr
);

    deser_state_t     state_q;
    logic [CNT_W-1:0] count_q;
    logic             dir_q;
    logic [WIDTH-1:0] sh_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic [WIDTH-1:0] shifted_s;
    logic             complete_s;
    logic             drop_s;

    // Next shift-register image and the last-bit-of-word condition.
    always_comb begin
        if (dir_q == DIR_MSB_FIRST) begin
            shifted_s = {sh_q[WIDTH-2:0], sdi};
        end else begin
            shifted_s = {sdi, sh_q[WIDTH-1:1]};
        end
        complete_s = (state_q == SHIFT) && sdi_valid
                     && (count_q == CNT_W'(WIDTH - 1));
    end

    // Frame FSM with bit counter, direction latch and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= {CNT_W{1'b0}};
            dir_q       <= DIR_LSB_FIRST;
            sh_q        <= {WIDTH{1'b0}};
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        count_q <= {CNT_W{1'b0}};
                        dir_q   <= msb_first;
                        sh_q    <= {WIDTH{1'b0}};
                    end
                end
                SHIFT: begin
                    if (complete_s) begin
                        // The finished word wins over a coincident start.
                        count_q <= {CNT_W{1'b0}};
                        sh_q    <= shifted_s;
                        if (start) begin
                            dir_q <= msb_first;
                        end else if (!cont) begin
                            state_q <= IDLE;
                        end
                    end else if (start) begin
                        count_q     <= {CNT_W{1'b0}};
                        dir_q       <= msb_first;
                        sh_q        <= {WIDTH{1'b0}};
                        frame_err_q <= 1'b1;
                    end else if (sdi_valid) begin
                        sh_q    <= shifted_s;
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Sticky overrun; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (drop_s) begin
            overrun_q <= 1'b1;
        end else if (clr_ovr) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_q;
        end
    end

    word_out_buf #(.WIDTH(WIDTH)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .load_req_i (complete_s),
        .word_i     (shifted_s),
        .ready_i    (word_ready),
        .word_o     (word_out),
        .valid_o    (word_valid),
        .drop_o     (drop_s)
    );

    assign busy      = (state_q == SHIFT);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule : serial_word_deser

// File: tb/tb_serial_word_deser.sv
// Scoreboard bench for serial_word_deser (WIDTH=4): expected words are queued
// by the stimulus and popped by a monitor on every output handshake.
module tb_serial_word_deser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       msb_first = 1'b1;
    logic       cont = 1'b0;
    logic       sdi = 1'b0;
    logic       sdi_valid = 1'b0;
    logic [3:0] word_out;
    logic       word_valid;
    logic       word_ready = 1'b0;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       clr_ovr = 1'b0;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] sb_q[$];

    serial_word_deser #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .msb_first  (msb_first),
        .cont       (cont),
        .sdi        (sdi),
        .sdi_valid  (sdi_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    // Monitor: every handshake seen away from the edge must match the queue head.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected: got %h, no word expected", word_out);
            end else begin
                logic [3:0] exp_w;
                exp_w = sb_q.pop_front();
                if (word_out !== exp_w) begin
                    errors++;
                    $display("FAIL word_out: got %h, expected %h", word_out, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic send_bit(input logic b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) tick();
        sdi       = b;
        sdi_valid = 1'b1;
        tick();
        sdi_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic msb);
        msb_first = msb;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Sends w in the chosen order; optionally raises word_ready on the last bit only.
    task automatic send_word(input logic msb, input logic [3:0] w, input logic ready_last);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && ready_last) word_ready = 1'b1;
            send_bit(msb ? w[3-i] : w[i], 0);
        end
        if (ready_last) word_ready = 1'b0;
    endtask

    task automatic consume();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset_word_out",   32'(word_out),   32'h0);
        chk("reset_word_valid", 32'(word_valid), 32'h0);
        chk("reset_busy",       32'(busy),       32'h0);
        chk("reset_overrun",    32'(overrun),    32'h0);

        // 1: MSB-first then LSB-first, latency of one cycle after the last bit.
        pulse_start(1'b1);
        chk("busy_after_start", 32'(busy), 32'h1);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        chk("valid_before_last", 32'(word_valid), 32'h0);
        sb_q.push_back(4'b1011);
        send_bit(1'b1, 0);
        chk("valid_after_last", 32'(word_valid), 32'h1);
        chk("msb_word",         32'(word_out),   32'hB);
        chk("idle_after_frame", 32'(busy),       32'h0);
        consume();
        chk("valid_cleared", 32'(word_valid), 32'h0);

        pulse_start(1'b0);
        sb_q.push_back(4'b1101);
        send_word(1'b0, 4'b1101, 1'b0);
        chk("lsb_word", 32'(word_out), 32'hD);
        consume();

        // 2: overrun while buffer is full; second word is dropped.
        pulse_start(1'b1);
        sb_q.push_back(4'hA);
        send_word(1'b1, 4'hA, 1'b0);
        pulse_start(1'b1);
        send_word(1'b1, 4'h5, 1'b0);
        chk("ovr_word_kept", 32'(word_out),   32'hA);
        chk("ovr_valid",     32'(word_valid), 32'h1);
        chk("ovr_set",       32'(overrun),    32'h1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'h0);
        consume();

        // 3: consume and load on the same edge.
        pulse_start(1'b1);
        sb_q.push_back(4'hA);
        send_word(1'b1, 4'hA, 1'b0);
        pulse_start(1'b1);
        sb_q.push_back(4'h5);
        send_word(1'b1, 4'h5, 1'b1);
        chk("swap_word",    32'(word_out),   32'h5);
        chk("swap_valid",   32'(word_valid), 32'h1);
        chk("swap_no_ovr",  32'(overrun),    32'h0);
        consume();

        // 4: restart mid-frame raises a single-cycle frame error.
        pulse_start(1'b1);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        chk("ferr_idle", 32'(frame_err), 32'h0);
        pulse_start(1'b1);
        chk("ferr_pulse", 32'(frame_err), 32'h1);
        tick();
        chk("ferr_end",  32'(frame_err), 32'h0);
        chk("ferr_busy", 32'(busy),      32'h1);
        sb_q.push_back(4'b0110);
        send_word(1'b1, 4'b0110, 1'b0);
        chk("ferr_word", 32'(word_out), 32'h6);
        consume();

        // 5: continuous mode, two words with gaps and a single start.
        cont       = 1'b1;
        word_ready = 1'b1;
        pulse_start(1'b1);
        sb_q.push_back(4'h9);
        sb_q.push_back(4'h3);
        begin
            logic [7:0] stream;
            stream = 8'h93;
            for (int i = 7; i >= 0; i--) begin
                send_bit(stream[i], 2);
                chk("cont_busy", 32'(busy), 32'h1);
            end
        end
        tick();
        word_ready = 1'b0;
        cont       = 1'b0;

        // 6: reset mid-frame clears everything, then a clean frame decodes.
        pulse_start(1'b1);
        send_word(1'b1, 4'hC, 1'b0);
        chk("pre_reset_valid", 32'(word_valid), 32'h1);
        pulse_start(1'b1);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_word_out",   32'(word_out),   32'h0);
        chk("rst_word_valid", 32'(word_valid), 32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        chk("rst_frame_err",  32'(frame_err),  32'h0);
        chk("rst_overrun",    32'(overrun),    32'h0);
        pulse_start(1'b1);
        sb_q.push_back(4'h6);
        send_word(1'b1, 4'h6, 1'b0);
        consume();

        tick();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_word_deser
